ascon_aead_sequencer: RTL and testbench

Phase sequencer for the Ascon-128 AEAD encrypt flow. It drives the shared permutation core with start pulses and round counts, and issues one-cycle datapath commands to the state-register block: IV load, block absorb, key XORs and domain separation. It also runs the block-input handshake on the host side and the tag-output handshake. It sits between the top-level I/O logic and the state controller / permutation pair.

---
 rtl/ascon_aead_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_ascon_aead_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead_sequencer.sv
// Ascon-128 AEAD encrypt phase sequencer: drives the permutation core and state-register commands.
// Latency: commands one cycle after the triggering edge; perm start two cycles after start/handshake.
// Backpressure: blk_ready only in AD/PT wait states; tag beats held until tag_ready; perm waits bounded by TIMEOUT.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   start_i, ad_present_i              operation request (IDLE only) and AD flag
//   blk_valid_i, blk_last_i, blk_ready_o   host block handshake (AD and PT phases)
//   perm_start_o, perm_rounds_o, perm_done_i   permutation core control
//   load_iv_o, absorb_o, key_xor_init_o, dom_sep_o, key_xor_final_o   one-cycle datapath commands
//   tag_valid_o, tag_idx_o, tag_ready_i    tag beat handshake
//   busy_o, done_o, error_o            status
module ascon_aead_sequencer #(
  parameter int unsigned ROUNDS_A  = 12,
  parameter int unsigned ROUNDS_B  = 6,
  parameter int unsigned TIMEOUT   = 63,
  parameter int unsigned TAG_BEATS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       ad_present_i,
  input  logic       blk_valid_i,
  input  logic       blk_last_i,
  output logic       blk_ready_o,
  output logic       perm_start_o,
  output logic [3:0] perm_rounds_o,
  input  logic       perm_done_i,
  output logic       load_iv_o,
  output logic       absorb_o,
  output logic       key_xor_init_o,
  output logic       dom_sep_o,
  output logic       key_xor_final_o,
  output logic       tag_valid_o,
  output logic [2:0] tag_idx_o,
  input  logic       tag_ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_KEYX,
    S_SEP,
    S_AD,
    S_ABS_A,
    S_AD_PERM,
    S_PT,
    S_ABS_P,
    S_PT_PERM,
    S_KEYF,
    S_FINAL,
    S_TAG
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       ad_present;
  logic       last_blk;
  logic       perm_first;   // current cycle is the first cycle of a permutation state
  logic [5:0] wait_cnt;
  logic [2:0] tag_idx;
  logic       done_q;
  logic       error_q;

  logic       in_perm;
  logic       next_in_perm;
  logic       perm_exit;
  logic       perm_timeout;
  logic       blk_hs;
  logic       tag_last;

  // perm_done_i is only meaningful after the start cycle; a done that coincides
  // with the timeout point wins over the timeout.
  always_comb begin
    in_perm      = (state == S_INIT) || (state == S_AD_PERM) ||
                   (state == S_PT_PERM) || (state == S_FINAL);
    next_in_perm = (state_next == S_INIT) || (state_next == S_AD_PERM) ||
                   (state_next == S_PT_PERM) || (state_next == S_FINAL);
    perm_exit    = in_perm && !perm_first && perm_done_i;
    perm_timeout = in_perm && !perm_first && !perm_done_i &&
                   (wait_cnt == 6'(TIMEOUT));
    blk_hs       = blk_valid_i && ((state == S_AD) || (state == S_PT));
    tag_last     = (state == S_TAG) && tag_ready_i &&
                   (tag_idx == 3'(TAG_BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    blk_ready_o     = 1'b0;
    perm_start_o    = 1'b0;
    perm_rounds_o   = 4'd0;
    load_iv_o       = 1'b0;
    absorb_o        = 1'b0;
    key_xor_init_o  = 1'b0;
    dom_sep_o       = 1'b0;
    key_xor_final_o = 1'b0;
    tag_valid_o     = 1'b0;
    busy_o          = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start_i) state_next = S_LOAD;
      end
      S_LOAD: begin
        load_iv_o  = 1'b1;
        state_next = S_INIT;
      end
      S_INIT: begin
        perm_start_o  = perm_first;
        perm_rounds_o = 4'(ROUNDS_A);
        if (perm_exit)         state_next = S_KEYX;
        else if (perm_timeout) state_next = S_IDLE;
      end
      S_KEYX: begin
        key_xor_init_o = 1'b1;
        state_next     = ad_present ? S_AD : S_SEP;
      end
      S_SEP: begin
        dom_sep_o  = 1'b1;
        state_next = S_PT;
      end
      S_AD: begin
        blk_ready_o = 1'b1;
        if (blk_hs) state_next = S_ABS_A;
      end
      S_ABS_A: begin
        absorb_o   = 1'b1;
        state_next = S_AD_PERM;
      end
      S_AD_PERM: begin
        perm_start_o  = perm_first;
        perm_rounds_o = 4'(ROUNDS_B);
        if (perm_exit)         state_next = last_blk ? S_SEP : S_AD;
        else if (perm_timeout) state_next = S_IDLE;
      end
      S_PT: begin
        blk_ready_o = 1'b1;
        if (blk_hs) state_next = S_ABS_P;
      end
      S_ABS_P: begin
        absorb_o   = 1'b1;
        // The last PT block skips the per-block permutation and goes straight
        // to finalisation.
        state_next = last_blk ? S_KEYF : S_PT_PERM;
      end
      S_PT_PERM: begin
        perm_start_o  = perm_first;
        perm_rounds_o = 4'(ROUNDS_B);
        if (perm_exit)         state_next = S_PT;
        else if (perm_timeout) state_next = S_IDLE;
      end
      S_KEYF: begin
        key_xor_final_o = 1'b1;
        state_next      = S_FINAL;
      end
      S_FINAL: begin
        perm_start_o  = perm_first;
        perm_rounds_o = 4'(ROUNDS_A);
        if (perm_exit)         state_next = S_TAG;
        else if (perm_timeout) state_next = S_IDLE;
      end
      S_TAG: begin
        tag_valid_o = 1'b1;
        if (tag_last) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ad_present <= 1'b0;
      last_blk   <= 1'b0;
      perm_first <= 1'b0;
      wait_cnt   <= 6'd0;
      tag_idx    <= 3'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= tag_last;

      if ((state == S_IDLE) && start_i) begin
        ad_present <= ad_present_i;
        error_q    <= 1'b0;
      end
      if (perm_timeout) error_q <= 1'b1;

      if (blk_hs) last_blk <= blk_last_i;

      // Permutation states are never entered from another permutation state,
      // so entry is simply "next is a perm state, current is not".
      perm_first <= next_in_perm && !in_perm;

      // Zero during the start cycle, then counts cycles spent waiting.
      if (!in_perm) begin
        wait_cnt <= 6'd0;
      end else if (wait_cnt != 6'h3f) begin
        wait_cnt <= wait_cnt + 6'd1;
      end

      if ((state == S_TAG) && tag_ready_i) begin
        tag_idx <= tag_last ? 3'd0 : (tag_idx + 3'd1);
      end
    end
  end

  assign tag_idx_o = tag_idx;
  assign done_o    = done_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_ascon_aead_sequencer.sv
// Bench for ascon_aead_sequencer: random and directed encrypt operations against a protocol-level model.
// Latency: model predicts each cycle's outputs from the previous cycle's inputs.
// Backpressure: host blocks, core completion and tag consumer are driven with random gaps.
module tb_ascon_aead_sequencer;

  localparam int TO = 63;

  // expected pulse codes
  localparam int E_NONE = 0, E_LOAD = 1, E_START = 2, E_KXI = 3, E_SEP = 4, E_ABS = 5, E_KXF = 6;
  // what the operation is waiting on
  localparam int W_NONE = 0, W_AD = 1, W_PT = 2, W_PERM = 3, W_TAG = 4;
  // permutation purpose
  localparam int K_INIT = 0, K_AD = 1, K_PT = 2, K_FIN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_main = 1'b0;
  logic       start_noise = 1'b0;
  logic       start_i;
  logic       ad_present_i = 1'b0;
  logic       blk_valid_i = 1'b0;
  logic       blk_last_i = 1'b0;
  logic       blk_ready_o;
  logic       perm_start_o;
  logic [3:0] perm_rounds_o;
  logic       perm_done_i = 1'b0;
  logic       load_iv_o, absorb_o, key_xor_init_o, dom_sep_o, key_xor_final_o;
  logic       tag_valid_o;
  logic [2:0] tag_idx_o;
  logic       tag_ready_i = 1'b0;
  logic       busy_o, done_o, error_o;

  assign start_i = start_main | start_noise;

  always #5 clk = ~clk;

  ascon_aead_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ad_present_i(ad_present_i),
    .blk_valid_i(blk_valid_i), .blk_last_i(blk_last_i), .blk_ready_o(blk_ready_o),
    .perm_start_o(perm_start_o), .perm_rounds_o(perm_rounds_o), .perm_done_i(perm_done_i),
    .load_iv_o(load_iv_o), .absorb_o(absorb_o), .key_xor_init_o(key_xor_init_o),
    .dom_sep_o(dom_sep_o), .key_xor_final_o(key_xor_final_o),
    .tag_valid_o(tag_valid_o), .tag_idx_o(tag_idx_o), .tag_ready_i(tag_ready_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_seq(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(nm, act[i], exp[i]);
  endtask

  // ---------------- model state (describes the current cycle) ----------------
  bit m_busy = 0, m_err = 0, m_done = 0, m_has_ad = 0, m_last = 0, m_first = 0;
  int m_exp = E_NONE, m_wait = W_NONE, m_rounds = 0, m_kind = K_INIT, m_cyc = 0, m_beat = 0;

  // event log and timestamps
  int act_q[$];
  int rnd_q[$];
  int done_cyc = -1, err_cyc = -1, tag_first_cyc = -1, done_cnt = 0;
  bit prev_err = 0, prev_tag = 0;

  always @(negedge clk) begin : mon
    int act;
    int nonz;
    int ne;
    bit nd;
    if (chk_en) begin
      nonz = int'(perm_start_o) + int'(load_iv_o) + int'(absorb_o) + int'(key_xor_init_o)
           + int'(dom_sep_o) + int'(key_xor_final_o);
      act = perm_start_o ? E_START : load_iv_o ? E_LOAD : key_xor_init_o ? E_KXI :
            dom_sep_o ? E_SEP : absorb_o ? E_ABS : key_xor_final_o ? E_KXF : E_NONE;
      chk("pulse_onehot", (nonz <= 1), 1);
      chk("pulse", act, m_exp);
      chk("rounds", perm_rounds_o, (m_wait == W_PERM) ? m_rounds : 0);
      chk("blk_ready", blk_ready_o, (m_wait == W_AD) || (m_wait == W_PT));
      chk("tag_valid", tag_valid_o, m_wait == W_TAG);
      chk("tag_idx", tag_idx_o, (m_wait == W_TAG) ? m_beat : 0);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("error", error_o, m_err);
      if (act != E_NONE) act_q.push_back(act);
      if (perm_start_o) rnd_q.push_back(int'(perm_rounds_o));
      if (done_o) begin done_cyc = cyc; done_cnt++; end
      if (error_o && !prev_err) err_cyc = cyc;
      if (tag_valid_o && !prev_tag) tag_first_cyc = cyc;
      prev_err = error_o;
      prev_tag = tag_valid_o;
    end

    // advance the model to the next cycle from this cycle's inputs
    ne = E_NONE;
    nd = 0;
    if (!rst_n) begin
      m_busy = 0; m_err = 0; m_has_ad = 0; m_last = 0; m_first = 0;
      m_wait = W_NONE; m_rounds = 0; m_kind = K_INIT; m_cyc = 0; m_beat = 0;
    end else if (!m_busy) begin
      if (start_i) begin
        m_busy = 1; m_err = 0; m_has_ad = ad_present_i; ne = E_LOAD; m_wait = W_NONE;
      end
    end else if (m_exp == E_LOAD) begin
      ne = E_START; m_wait = W_PERM; m_kind = K_INIT; m_rounds = 12; m_first = 1; m_cyc = 0;
    end else if (m_exp == E_KXI) begin
      if (m_has_ad) m_wait = W_AD;
      else ne = E_SEP;
    end else if (m_exp == E_SEP) begin
      m_wait = W_PT;
    end else if (m_exp == E_ABS) begin
      if (m_kind == K_PT && m_last) ne = E_KXF;
      else begin ne = E_START; m_wait = W_PERM; m_rounds = 6; m_first = 1; m_cyc = 0; end
    end else if (m_exp == E_KXF) begin
      ne = E_START; m_wait = W_PERM; m_kind = K_FIN; m_rounds = 12; m_first = 1; m_cyc = 0;
    end else if (m_wait == W_PERM) begin
      if (m_first) begin
        m_first = 0; m_cyc = 1;
      end else if (perm_done_i) begin
        case (m_kind)
          K_INIT:  begin m_wait = W_NONE; ne = E_KXI; end
          K_AD:    begin if (m_last) begin m_wait = W_NONE; ne = E_SEP; end else m_wait = W_AD; end
          K_PT:    m_wait = W_PT;
          default: begin m_wait = W_TAG; m_beat = 0; end
        endcase
      end else if (m_cyc >= TO) begin
        m_busy = 0; m_err = 1; m_wait = W_NONE;
      end else begin
        m_cyc++;
      end
    end else if (m_wait == W_AD || m_wait == W_PT) begin
      if (blk_valid_i) begin
        m_last = blk_last_i; m_kind = (m_wait == W_AD) ? K_AD : K_PT; m_wait = W_NONE; ne = E_ABS;
      end
    end else if (m_wait == W_TAG) begin
      if (tag_ready_i) begin
        if (m_beat == 7) begin m_busy = 0; m_wait = W_NONE; nd = 1; m_beat = 0; end
        else m_beat++;
      end
    end
    m_exp = ne;
    m_done = nd;
  end

  // ---------------- permutation core emulator ----------------
  int  core_delay = 0;
  bit  core_mute = 0, spur_first = 0, spur_idle = 0;
  bit  pend = 0;
  int  pcnt = 0;

  always @(posedge clk) begin
    #2;
    perm_done_i = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else if (perm_start_o) begin
      pend = !core_mute;
      pcnt = (core_delay > 0) ? core_delay : int'($urandom_range(1, 20));
      if (spur_first && ($urandom % 2 == 0)) perm_done_i = 1'b1;
    end else if (pend) begin
      pcnt--;
      if (pcnt == 0) begin perm_done_i = 1'b1; pend = 0; end
    end else if (spur_idle && ($urandom % 6 == 0)) begin
      perm_done_i = 1'b1;
    end
  end

  // ---------------- host block source ----------------
  int h_ad = 0, h_pt = 0;
  bit h_gaps = 1, h_fire = 0;

  always begin
    @(negedge clk);
    h_fire = blk_valid_i && blk_ready_o;
    @(posedge clk);
    #2;
    if (h_fire) begin
      if (h_ad > 0) h_ad--;
      else if (h_pt > 0) h_pt--;
    end
    if (h_ad + h_pt == 0) begin
      blk_valid_i = h_gaps && ($urandom % 4 == 0);
      blk_last_i  = $urandom % 2;
    end else begin
      blk_valid_i = !h_gaps || ($urandom % 3 != 0);
      blk_last_i  = (h_ad > 0) ? (h_ad == 1) : (h_pt == 1);
    end
  end

  // ---------------- tag consumer and start noise ----------------
  int t_mode = 0;   // 0 random, 1 always ready, 2 toggle
  bit n_start_en = 0;

  always @(posedge clk) begin
    #2;
    case (t_mode)
      1:       tag_ready_i = 1'b1;
      2:       tag_ready_i = ~tag_ready_i;
      default: tag_ready_i = $urandom % 2;
    endcase
    start_noise = n_start_en && (m_wait == W_PT) && ($urandom % 3 == 0);
  end

  // ---------------- sequencing ----------------
  task automatic run_op(input int na, input int np, output int c0);
    @(posedge clk); #1;
    h_ad = na; h_pt = np;
    act_q.delete(); rnd_q.delete();
    done_cyc = -1; err_cyc = -1; tag_first_cyc = -1; done_cnt = 0;
    start_main = 1'b1; ad_present_i = (na > 0); c0 = cyc;
    @(posedge clk); #1;
    start_main = 1'b0; ad_present_i = $urandom % 2;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!m_busy) begin ok = 1; break; end
    end
    if (!ok) chk("op_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0;
    int exp_a[$];
    int exp_ar[$];
    int exp_b[$];
    int exp_br[$];
    int span;
    bit found;
    exp_a  = '{1, 2, 3, 4, 5, 6, 2};
    exp_ar = '{12, 12};
    exp_b  = '{1, 2, 3, 5, 2, 5, 2, 4, 5, 2, 5, 2, 5, 6, 2};
    exp_br = '{12, 6, 6, 6, 6, 12};

    // reset
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("reset_outputs", {blk_ready_o, perm_start_o, perm_rounds_o, load_iv_o, absorb_o,
        key_xor_init_o, dom_sep_o, key_xor_final_o, tag_valid_o, tag_idx_o, busy_o, done_o, error_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // no AD, one PT block, core answers 12 cycles after start, tag always consumed
    core_delay = 12; h_gaps = 0; t_mode = 1;
    run_op(0, 1, c0);
    wait_idle(500);
    chk_seq("seq_noad", act_q, exp_a);
    chk_seq("rounds_noad", rnd_q, exp_ar);
    chk("done_latency", done_cyc - c0, 41);

    // two AD blocks, three PT blocks, random core latency and host gaps
    core_delay = 0; h_gaps = 1; t_mode = 0;
    run_op(2, 3, c0);
    wait_idle(2000);
    chk_seq("seq_ad2pt3", act_q, exp_b);
    chk_seq("rounds_ad2pt3", rnd_q, exp_br);

    // tag backpressure: ready toggles every other cycle
    t_mode = 2;
    run_op(1, 2, c0);
    wait_idle(2000);
    span = done_cyc - tag_first_cyc;
    chk("tag_toggle_span", (span == 15) || (span == 16), 1);
    chk("tag_toggle_done_once", done_cnt, 1);

    // spurious starts in PT, spurious core completions
    t_mode = 0; spur_first = 1; spur_idle = 1; n_start_en = 1;
    run_op(1, 3, c0);
    wait_idle(2000);
    chk("spur_done_once", done_cnt, 1);
    spur_first = 0; spur_idle = 0; n_start_en = 0;

    // core never answers in INIT
    core_mute = 1;
    run_op(0, 1, c0);
    wait_idle(500);
    chk("timeout_latency", err_cyc - c0, 66);
    chk("timeout_no_done", done_cnt, 0);
    chk("timeout_busy", busy_o, 0);
    core_mute = 0; h_ad = 0; h_pt = 0;
    run_op(0, 2, c0);
    @(negedge clk);
    chk("error_cleared", error_o, 0);
    wait_idle(2000);

    // reset pulse in the middle of FINAL
    core_delay = 15;
    run_op(1, 1, c0);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (m_wait == W_PERM && m_kind == K_FIN && !m_first) begin found = 1; break; end
    end
    chk("final_reached", found, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {blk_ready_o, perm_start_o, perm_rounds_o, load_iv_o, absorb_o,
        key_xor_init_o, dom_sep_o, key_xor_final_o, tag_valid_o, tag_idx_o, busy_o, done_o, error_o}, 0);
    core_delay = 0;
    run_op(0, 1, c0);
    wait_idle(2000);
    chk_seq("seq_after_reset", act_q, exp_a);

    // random operations
    spur_first = 1; spur_idle = 1; n_start_en = 1;
    for (int k = 0; k < 12; k++) begin
      t_mode = $urandom_range(0, 2);
      run_op($urandom_range(0, 3), $urandom_range(1, 4), c0);
      wait_idle(3000);
      chk("rand_done_once", done_cnt, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
